// File: rtl/ram_1r1w_arb.sv
// Two-writer / two-reader round-robin front end for a 1R1W RAM with fixed read latency.
// Optional macro RAM_ARB_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram_1r1w_arb #(
    parameter int NWORDS  = 1024,
    parameter int WORDSZ  = 32,
    parameter int ADDRSZ  = $clog2(NWORDS),
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wr_valid,
    input  logic [2*ADDRSZ-1:0]   wr_addr,
    input  logic [2*WORDSZ-1:0]   wr_data,
    output logic [1:0]            wr_ready,
    input  logic [1:0]            rd_valid,
    input  logic [2*ADDRSZ-1:0]   rd_addr,
    output logic [1:0]            rd_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [WORDSZ-1:0]     rsp_data,
    output logic                  ram_we,
    output logic [ADDRSZ-1:0]     ram_waddr,
    output logic [WORDSZ-1:0]     ram_wdata,
    output logic                  ram_re,
    output logic [ADDRSZ-1:0]     ram_raddr,
    input  logic [WORDSZ-1:0]     ram_rdata
);

    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          w_wgnt;
    logic [1:0]          w_rgnt;
    logic [ADDRSZ-1:0]   w_waddr;
    logic [ADDRSZ-1:0]   w_raddr;
    logic [WORDSZ-1:0]   w_wdata;
    logic [WORDSZ-1:0]   w_rdata;
    logic [RAM_LAT:1]    r_vld_pipe;
    logic [RAM_LAT:1]    r_id_pipe;

    // Pointer names the winner on contention; a lone requester always wins.
    always_comb begin
        w_wgnt = 2'b00;
        w_rgnt = 2'b00;
        if (!rst) begin
            w_wgnt = (wr_valid == 2'b11) ? (r_wptr ? 2'b10 : 2'b01) : wr_valid;
            w_rgnt = (rd_valid == 2'b11) ? (r_rptr ? 2'b10 : 2'b01) : rd_valid;
        end
    end

    assign wr_ready = w_wgnt;
    assign rd_ready = w_rgnt;

    assign w_waddr = w_wgnt[1] ? wr_addr[2*ADDRSZ-1:ADDRSZ] : wr_addr[ADDRSZ-1:0];
    assign w_wdata = w_wgnt[1] ? wr_data[2*WORDSZ-1:WORDSZ] : wr_data[WORDSZ-1:0];
    assign w_raddr = w_rgnt[1] ? rd_addr[2*ADDRSZ-1:ADDRSZ] : rd_addr[ADDRSZ-1:0];

    assign ram_we    = |w_wgnt;
    assign ram_waddr = ram_we ? w_waddr : '0;
    assign ram_wdata = ram_we ? w_wdata : '0;
    assign ram_re    = |w_rgnt;
    assign ram_raddr = ram_re ? w_raddr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (wr_valid == 2'b11) r_wptr <= ~r_wptr;
            if (rd_valid == 2'b11) r_rptr <= ~r_rptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_vld_pipe[1] <= ram_re;
            r_id_pipe[1]  <= w_rgnt[1];
            for (int k = 2; k <= RAM_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_id_pipe[k]  <= r_id_pipe[k-1];
            end
        end
    end

`ifdef RAM_ARB_BYPASS_EN
    logic                          w_col;
    logic [RAM_LAT:1]              r_col_pipe;
    logic [RAM_LAT:1][WORDSZ-1:0]  r_byp_pipe;

    // RAM is read-before-write, so a colliding read must take the new data from here.
    assign w_col = ram_we & ram_re & (w_waddr == w_raddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_pipe <= '0;
            r_byp_pipe <= '0;
        end else begin
            r_col_pipe[1] <= w_col;
            r_byp_pipe[1] <= w_wdata;
            for (int k = 2; k <= RAM_LAT; k++) begin
                r_col_pipe[k] <= r_col_pipe[k-1];
                r_byp_pipe[k] <= r_byp_pipe[k-1];
            end
        end
    end

    assign w_rdata = r_col_pipe[RAM_LAT] ? r_byp_pipe[RAM_LAT] : ram_rdata;
`else
    assign w_rdata = ram_rdata;
`endif

    assign rsp_valid = r_vld_pipe[RAM_LAT] & ~rst;
    assign rsp_id    = rsp_valid & r_id_pipe[RAM_LAT];
    assign rsp_data  = rsp_valid ? w_rdata : '0;

endmodule

// File: doc/ram_1r1w_arb.md
RAM_1R1W_ARB -- requirements
Module: ram_1r1w_arb

Interface
REQ-001 SHALL have parameter NWORDS, default 1024: RAM depth in words.
REQ-002 SHALL have parameter WORDSZ, default 32: data width.
REQ-003 SHALL have parameter ADDRSZ, default LOG2(NWORDS): address width.
REQ-004 SHALL have parameter RAM_LAT, default 1: RAM read latency in cycles, legal range 1..2.
REQ-005 SHALL have port clk  in  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-007 SHALL have ports wr_valid  in  2, wr_addr  in  2*ADDRSZ, wr_data  in  2*WORDSZ, wr_ready  out  2: write requesters 0/1 (slice i belongs to requester i).
REQ-008 SHALL have ports rd_valid  in  2, rd_addr  in  2*ADDRSZ, rd_ready  out  2: read requesters 0/1.
REQ-009 SHALL have ports rsp_valid  out  1, rsp_id  out  1, rsp_data  out  WORDSZ: read response, with no backpressure.
REQ-010 SHALL have ports ram_we  out  1, ram_waddr  out  ADDRSZ, ram_wdata  out  WORDSZ: RAM write port.
REQ-011 SHALL have ports ram_re  out  1, ram_raddr  out  ADDRSZ, ram_rdata  in  WORDSZ: RAM read port.

Function
REQ-012 SHALL arbitrate the write side and the read side independently; at most one write and one read issued per cycle.
REQ-013 SHALL compute grants combinationally: a request transfers in the cycle where valid and ready are both high.
REQ-014 SHALL assert ready only to the granted requester; wr_ready/rd_ready SHALL be 0 for non-requesting ports.
REQ-015 SHALL arbitrate each side round-robin with a 1-bit pointer: pointer=p means requester p wins when both request.
REQ-016 SHALL set the pointer to the loser after a cycle in which both requested; SHALL leave the pointer unchanged if only one or neither requested.
REQ-017 SHALL, on a write grant, drive ram_we=1 with the granted address/data in the same cycle; SHALL hold ram_we=0 otherwise.
REQ-018 SHALL, on a read grant, drive ram_re=1 and ram_raddr in the same cycle; SHALL hold ram_re=0 otherwise.
REQ-019 SHALL track each issued read in a RAM_LAT-deep shift pipeline of {valid, id}.
REQ-020 SHALL assert rsp_valid exactly RAM_LAT cycles after the read grant, with rsp_id equal to the granted requester and rsp_data taken from ram_rdata.
REQ-021 SHALL sustain one read response per cycle under back-to-back reads with no bubbles.
REQ-022 SHALL hold rsp_id and rsp_data at 0 when rsp_valid=0.
REQ-023 SHALL treat a same-cycle read and write to the same address as a collision; the resulting response data is defined by the configuration section.

Reset
REQ-024 SHALL, while rst=1, drive rsp_valid, rsp_id, rsp_data, ram_we and ram_re to 0, and clear both round-robin pointers to 0.
REQ-025 SHALL, while rst=1, hold wr_ready and rd_ready at 0 and clear all read-pipeline entries.
REQ-026 SHALL discard in-flight reads when reset is asserted mid-operation: no rsp_valid for them after reset releases.

Configuration
REQ-027 SHALL, with macro RAM_ARB_BYPASS_EN defined, register the collision flag and write data alongside the read pipeline.
REQ-028 SHALL, with RAM_ARB_BYPASS_EN defined, return the registered write data on rsp_data for a collided read, so the read sees the new value.
REQ-029 SHALL, with RAM_ARB_BYPASS_EN undefined, return ram_rdata unconditionally; no collision logic is present.

Verification
REQ-030 Bench SHALL cover: both write requesters valid for 4 cycles from reset, addr0=0x10, addr1=0x20 -> ram_waddr sequence 0x10, 0x20, 0x10, 0x20.
REQ-031 Bench SHALL cover: RAM_LAT=2, reads from requester 1 at 0x5 (cycle 0) and requester 0 at 0x6 (cycle 1) -> rsp_valid in cycles 2 and 3 with rsp_id 1 then 0 and matching data.
REQ-032 Bench SHALL cover: only rd_valid[1] high with pointer=0 -> rd_ready[1]=1 in the same cycle and pointer stays 0.
REQ-033 Bench SHALL cover: RAM_ARB_BYPASS_EN defined, write 0xDEAD to 0x3 in the same cycle as a read of 0x3 -> rsp_data=0xDEAD after RAM_LAT cycles; undefined -> rsp_data equals ram_rdata.
REQ-034 Bench SHALL cover: rst pulsed one cycle after a read grant with RAM_LAT=2 -> rsp_valid stays 0 and all outputs are 0 during reset.
REQ-035 Bench SHALL cover: 100 cycles of random concurrent traffic against a reference memory model -> every response matches, and no requester waits more than 1 cycle while the other side is contended.
